// File: rtl/csr_pkg.sv
// Shared definitions for the CSR read-modify-write unit: op encodings,
// FSM states and the read-only CSR address space.
package csr_pkg;

  localparam int CSROP_LEN = 3;

  typedef enum logic [CSROP_LEN-1:0] {
    CSR_NONE  = 3'd0,
    CSR_READ  = 3'd1,
    CSR_WRITE = 3'd2,
    CSR_SET   = 3'd3,
    CSR_CLEAR = 3'd4
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WB   = 2'd2,
    ST_RESP = 2'd3
  } csr_state_e;

  // CSRs whose address bits [11:10] are 2'b11 are read-only.
  localparam logic [1:0] CSR_RO_SPACE = 2'b11;

  function automatic logic is_ro_addr(input logic [11:0] addr);
    return addr[11:10] == CSR_RO_SPACE;
  endfunction

  function automatic logic op_is_rmw(input csr_op_e op);
    return (op == CSR_SET) || (op == CSR_CLEAR);
  endfunction

endpackage

// File: rtl/csr_rmw_unit_if.sv
// Request/response handshake plus CSR-file read/write port of the RMW unit.
// slave: the RMW unit; master: the requester / CSR-file side.
interface csr_rmw_unit_if
  import csr_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int IMM_LEN = 5
);

  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [CSROP_LEN-1:0] csr_op_i;
  logic [11:0]          csr_addr_i;
  logic [IMM_LEN-1:0]   csr_imm_i;
  logic                 csr_imm_valid_i;
  logic [XLEN-1:0]      rs1_data_i;
  logic                 src_zero_i;
  logic                 flush_i;

  logic                 csr_rd_en_o;
  logic [11:0]          csr_rd_addr_o;
  logic [XLEN-1:0]      csr_rd_data_i;
  logic                 csr_rd_err_i;
  logic                 csr_wr_en_o;
  logic [11:0]          csr_wr_addr_o;
  logic [XLEN-1:0]      csr_wr_data_o;

  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [XLEN-1:0]      out_rd_data_o;
  logic                 out_illegal_o;

  modport slave (
    input  in_valid_i, csr_op_i, csr_addr_i, csr_imm_i, csr_imm_valid_i,
           rs1_data_i, src_zero_i, flush_i,
           csr_rd_data_i, csr_rd_err_i, out_ready_i,
    output in_ready_o, csr_rd_en_o, csr_rd_addr_o,
           csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o,
           out_valid_o, out_rd_data_o, out_illegal_o
  );

  modport master (
    output in_valid_i, csr_op_i, csr_addr_i, csr_imm_i, csr_imm_valid_i,
           rs1_data_i, src_zero_i, flush_i,
           csr_rd_data_i, csr_rd_err_i, out_ready_i,
    input  in_ready_o, csr_rd_en_o, csr_rd_addr_o,
           csr_wr_en_o, csr_wr_addr_o, csr_wr_data_o,
           out_valid_o, out_rd_data_o, out_illegal_o
  );

endinterface

// File: rtl/csr_alu.sv
// Combinational CSR op evaluation: new value and whether the op writes at all.
module csr_alu
  import csr_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  csr_op_e         op_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] op2_i,
  output logic [XLEN-1:0] new_o,
  output logic            write_req_o
);

  always_comb begin
    new_o       = '0;
    write_req_o = 1'b0;
    case (op_i)
      CSR_WRITE: begin
        new_o       = op2_i;
        write_req_o = 1'b1;
      end
      CSR_SET: begin
        new_o       = old_i | op2_i;
        write_req_o = 1'b1;
      end
      CSR_CLEAR: begin
        new_o       = old_i & ~op2_i;
        write_req_o = 1'b1;
      end
      default: begin
        new_o       = '0;
        write_req_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/csr_rmw_unit.sv
// CSR read-modify-write sequencer: one request at a time through read,
// write-back and response phases, with flush and illegal-access handling.
//   state   | meaning
//   IDLE    | ready for a request
//   RD      | read strobe to CSR file
//   WB      | old value returns, write strobe if legal
//   RESP    | hold result until consumer takes it
module csr_rmw_unit
  import csr_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int IMM_LEN = 5
) (
  input  logic          clk,
  input  logic          rst,
  csr_rmw_unit_if.slave bus
);

  csr_state_e      state_q, state_d;
  csr_op_e         op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] op2_q, op2_d;
  logic [XLEN-1:0] old_q, old_d;
  logic            src_zero_q, src_zero_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] alu_new;
  logic            alu_write_req;
  logic            write_eff;
  logic            illegal_now;
  logic            in_ready;
  logic            rd_en;
  logic            wr_en;
  logic            out_valid;
  logic            rd_en_o;
  logic            wr_en_o;
  logic            out_valid_o;

  assign imm_ext = {{(XLEN-IMM_LEN){1'b0}}, bus.csr_imm_i};

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op_i        (op_q),
    .old_i       (bus.csr_rd_data_i),
    .op2_i       (op2_q),
    .new_o       (alu_new),
    .write_req_o (alu_write_req)
  );

  // A zero source turns SET/CLEAR into a pure read, so read-only CSRs stay legal.
  assign write_eff   = alu_write_req && !(src_zero_q && op_is_rmw(op_q));
  assign illegal_now = bus.csr_rd_err_i || (write_eff && is_ro_addr(addr_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= CSR_NONE;
      addr_q     <= '0;
      op2_q      <= '0;
      src_zero_q <= 1'b0;
      old_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      op2_q      <= op2_d;
      src_zero_q <= src_zero_d;
      old_q      <= old_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    op2_d      = op2_q;
    src_zero_d = src_zero_q;
    old_d      = old_q;
    illegal_d  = illegal_q;
    in_ready   = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    out_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = !bus.flush_i;
        if (bus.in_valid_i && !bus.flush_i) begin
          op_d       = csr_op_e'(bus.csr_op_i);
          addr_d     = bus.csr_addr_i;
          op2_d      = bus.csr_imm_valid_i ? imm_ext : bus.rs1_data_i;
          src_zero_d = bus.src_zero_i;
          state_d    = ST_RD;
        end
      end
      ST_RD: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          rd_en   = 1'b1;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          wr_en     = write_eff && !illegal_now;
          old_d     = illegal_now ? '0 : bus.csr_rd_data_i;
          illegal_d = illegal_now;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.flush_i) begin
          state_d = ST_IDLE;
        end else begin
          out_valid = 1'b1;
          if (bus.out_ready_i) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes are gated by rst so they drop the instant reset is asserted.
  assign rd_en_o     = rd_en & ~rst;
  assign wr_en_o     = wr_en & ~rst;
  assign out_valid_o = out_valid & ~rst;

  assign bus.in_ready_o    = in_ready & ~rst;
  assign bus.csr_rd_en_o   = rd_en_o;
  assign bus.csr_rd_addr_o = rd_en_o ? addr_q : '0;
  assign bus.csr_wr_en_o   = wr_en_o;
  assign bus.csr_wr_addr_o = wr_en_o ? addr_q : '0;
  assign bus.csr_wr_data_o = wr_en_o ? alu_new : '0;
  assign bus.out_valid_o   = out_valid_o;
  assign bus.out_rd_data_o = out_valid_o ? old_q : '0;
  assign bus.out_illegal_o = out_valid_o & illegal_q;

endmodule

// File: tb/tb_csr_rmw_unit.sv
// Self-checking bench for csr_rmw_unit: CSR-file model, write/response scoreboard,
// and directed scenario tasks.
module tb_csr_rmw_unit;
  import csr_pkg::*;

  localparam int XLEN    = 64;
  localparam int IMM_LEN = 5;
  localparam logic [11:0] ERR_ADDR = 12'h7FF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_rmw_unit_if #(.XLEN(XLEN), .IMM_LEN(IMM_LEN)) bus ();

  csr_rmw_unit #(.XLEN(XLEN), .IMM_LEN(IMM_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct { logic [63:0] rd; logic ill; } resp_t;
  typedef struct { logic [11:0] addr; logic [63:0] data; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];

  logic [63:0] csr_file [0:4095];
  logic [63:0] shadow   [0:4095];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [63:0] pl_data;

  // CSR file: data/err one cycle after the read strobe, writes land on the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.csr_rd_data_i <= '0;
      bus.csr_rd_err_i  <= 1'b0;
    end else begin
      if (bus.csr_rd_en_o) begin
        bus.csr_rd_data_i <= csr_file[bus.csr_rd_addr_o];
        bus.csr_rd_err_i  <= (bus.csr_rd_addr_o == ERR_ADDR);
      end else begin
        bus.csr_rd_data_i <= '0;
        bus.csr_rd_err_i  <= 1'b0;
      end
      if (bus.csr_wr_en_o) csr_file[bus.csr_wr_addr_o] <= bus.csr_wr_data_o;
      if (pl_en) csr_file[pl_addr] <= pl_data;
    end
  end

  always @(negedge clk) begin : mon
    wr_t   ew;
    resp_t er;
    if (!rst) begin
      if (bus.csr_wr_en_o) begin
        total++;
        if (wr_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write got addr=%h data=%h exp none", bus.csr_wr_addr_o, bus.csr_wr_data_o);
        end else begin
          ew = wr_q.pop_front();
          if (bus.csr_wr_addr_o !== ew.addr || bus.csr_wr_data_o !== ew.data) begin
            bad++;
            $display("FAIL write got addr=%h data=%h exp addr=%h data=%h", bus.csr_wr_addr_o, bus.csr_wr_data_o, ew.addr, ew.data);
          end
        end
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        total++;
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp got data=%h ill=%b exp none", bus.out_rd_data_o, bus.out_illegal_o);
        end else begin
          er = resp_q.pop_front();
          if (bus.out_rd_data_o !== er.rd || bus.out_illegal_o !== er.ill) begin
            bad++;
            $display("FAIL resp got data=%h ill=%b exp data=%h ill=%b", bus.out_rd_data_o, bus.out_illegal_o, er.rd, er.ill);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [11:0] a, input logic [63:0] v);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = v; shadow[a] = v;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Drives one request; returns one cycle after acceptance (DUT in RD).
  task automatic issue(input csr_op_e op, input logic [11:0] addr, input logic [4:0] imm,
                       input logic imm_v, input logic [63:0] rs1, input logic sz,
                       input logic push, output logic ok);
    logic [63:0] op2, old, nv;
    logic wr, ill, err;
    op2 = imm_v ? {59'b0, imm} : rs1;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b1; bus.csr_op_i = op; bus.csr_addr_i = addr; bus.csr_imm_i = imm;
    bus.csr_imm_valid_i = imm_v; bus.rs1_data_i = rs1; bus.src_zero_i = sz;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready_o === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout got ready=%b exp 1", bus.in_ready_o);
      bus.in_valid_i = 1'b0;
      return;
    end
    if (push) begin
      old = shadow[addr];
      err = (addr == ERR_ADDR);
      wr  = (op == CSR_WRITE) || ((op == CSR_SET || op == CSR_CLEAR) && !sz);
      nv  = (op == CSR_WRITE) ? op2 : (op == CSR_SET) ? (old | op2) : (old & ~op2);
      ill = err || (wr && addr[11:10] == 2'b11);
      resp_q.push_back('{rd: ill ? 64'h0 : old, ill: ill});
      if (wr && !ill) begin
        wr_q.push_back('{addr: addr, data: nv});
        shadow[addr] = nv;
      end
    end
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resp_q.size() == 0 && wr_q.size() == 0 && bus.in_ready_o === 1'b1) begin done = 1'b1; break; end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout got pending resp=%0d wr=%0d exp 0", resp_q.size(), wr_q.size());
      resp_q.delete(); wr_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid_i = 0; bus.csr_op_i = '0; bus.csr_addr_i = '0; bus.csr_imm_i = '0;
    bus.csr_imm_valid_i = 0; bus.rs1_data_i = '0; bus.src_zero_i = 0; bus.flush_i = 0;
    bus.out_ready_i = 1'b1; pl_en = 0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 4096; i++) shadow[i] = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.in_ready_o, bus.csr_rd_en_o, bus.csr_wr_en_o, bus.out_valid_o, bus.out_illegal_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_strobes got %b exp 00000", {bus.in_ready_o, bus.csr_rd_en_o, bus.csr_wr_en_o, bus.out_valid_o, bus.out_illegal_o});
    end
    total++;
    if (bus.out_rd_data_o !== 64'h0 || bus.csr_wr_data_o !== 64'h0 || bus.csr_rd_addr_o !== 12'h0) begin
      bad++;
      $display("FAIL reset_data got rd=%h wd=%h ra=%h exp 0", bus.out_rd_data_o, bus.csr_wr_data_o, bus.csr_rd_addr_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready got %b exp 1", bus.in_ready_o); end
  endtask

  task automatic test_write();
    logic ok;
    preload(12'h340, 64'h5);
    issue(CSR_WRITE, 12'h340, 5'd0, 1'b0, 64'hDEAD, 1'b0, 1'b1, ok);
    if (ok) begin
      @(negedge clk);
      total++;
      if (bus.csr_rd_en_o !== 1'b1 || bus.csr_rd_addr_o !== 12'h340) begin
        bad++; $display("FAIL write_rd_strobe got en=%b addr=%h exp en=1 addr=340", bus.csr_rd_en_o, bus.csr_rd_addr_o);
      end
      @(negedge clk);
      total++;
      if (bus.csr_wr_en_o !== 1'b1 || bus.csr_wr_data_o !== 64'hDEAD || bus.csr_rd_en_o !== 1'b0) begin
        bad++; $display("FAIL write_wb got wr=%b data=%h rd=%b exp wr=1 data=dead rd=0", bus.csr_wr_en_o, bus.csr_wr_data_o, bus.csr_rd_en_o);
      end
      @(negedge clk);
      total++;
      if (bus.out_valid_o !== 1'b1 || bus.out_rd_data_o !== 64'h5 || bus.out_illegal_o !== 1'b0) begin
        bad++; $display("FAIL write_resp got v=%b data=%h ill=%b exp v=1 data=5 ill=0", bus.out_valid_o, bus.out_rd_data_o, bus.out_illegal_o);
      end
    end
    wait_done();
  endtask

  task automatic test_set_clear();
    logic ok;
    preload(12'h300, 64'h3);
    issue(CSR_SET, 12'h300, 5'b10100, 1'b1, 64'hFFFF_0000, 1'b0, 1'b1, ok);
    wait_done();
    total++;
    if (csr_file[12'h300] !== 64'h17) begin bad++; $display("FAIL set_result got %h exp 17", csr_file[12'h300]); end
    issue(CSR_CLEAR, 12'h300, 5'd0, 1'b0, 64'h17, 1'b1, 1'b1, ok);
    if (ok) begin
      @(negedge clk); @(negedge clk);
      total++;
      if (bus.csr_wr_en_o !== 1'b0) begin bad++; $display("FAIL clear_zero_wr got %b exp 0", bus.csr_wr_en_o); end
    end
    wait_done();
    total++;
    if (csr_file[12'h300] !== 64'h17) begin bad++; $display("FAIL clear_zero_unchanged got %h exp 17", csr_file[12'h300]); end
    issue(CSR_CLEAR, 12'h300, 5'd0, 1'b0, 64'h4, 1'b0, 1'b1, ok);
    wait_done();
    total++;
    if (csr_file[12'h300] !== 64'h13) begin bad++; $display("FAIL clear_result got %h exp 13", csr_file[12'h300]); end
  endtask

  task automatic test_illegal();
    logic ok;
    preload(12'hC00, 64'h99);
    preload(12'hC01, 64'h7);
    preload(ERR_ADDR, 64'h55);
    issue(CSR_WRITE, 12'hC00, 5'd0, 1'b0, 64'h1, 1'b0, 1'b1, ok);
    if (ok) begin
      @(negedge clk); @(negedge clk);
      total++;
      if (bus.csr_wr_en_o !== 1'b0) begin bad++; $display("FAIL ro_write_wr got %b exp 0", bus.csr_wr_en_o); end
      @(negedge clk);
      total++;
      if (bus.out_valid_o !== 1'b1 || bus.out_illegal_o !== 1'b1 || bus.out_rd_data_o !== 64'h0) begin
        bad++; $display("FAIL ro_write_resp got v=%b ill=%b data=%h exp v=1 ill=1 data=0", bus.out_valid_o, bus.out_illegal_o, bus.out_rd_data_o);
      end
    end
    wait_done();
    issue(CSR_READ, ERR_ADDR, 5'd0, 1'b0, 64'h0, 1'b0, 1'b1, ok);
    wait_done();
    issue(CSR_READ, 12'hC00, 5'd0, 1'b0, 64'h0, 1'b0, 1'b1, ok);
    wait_done();
    issue(CSR_SET, 12'hC01, 5'd3, 1'b1, 64'h0, 1'b1, 1'b1, ok);
    wait_done();
    issue(CSR_SET, 12'hC01, 5'd3, 1'b1, 64'h0, 1'b0, 1'b1, ok);
    wait_done();
    total++;
    if (csr_file[12'hC00] !== 64'h99 || csr_file[12'hC01] !== 64'h7) begin
      bad++; $display("FAIL ro_unchanged got c00=%h c01=%h exp 99 7", csr_file[12'hC00], csr_file[12'hC01]);
    end
  endtask

  task automatic test_backpressure();
    logic ok, seen;
    preload(12'h341, 64'hABCD);
    bus.out_ready_i = 1'b0;
    issue(CSR_READ, 12'h341, 5'd0, 1'b0, 64'h0, 1'b0, 1'b1, ok);
    seen = 1'b0;
    for (int i = 0; i < 10 && ok; i++) begin
      @(negedge clk);
      if (bus.out_valid_o === 1'b1) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_valid_timeout got 0 exp 1"); end
    for (int i = 0; i < 4 && seen; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (bus.out_valid_o !== 1'b1 || bus.out_rd_data_o !== 64'hABCD || bus.in_ready_o !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got v=%b data=%h rdy=%b exp v=1 data=abcd rdy=0", i, bus.out_valid_o, bus.out_rd_data_o, bus.in_ready_o);
      end
    end
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    wait_done();
  endtask

  task automatic test_flush();
    logic ok, seen;
    int vcount;
    preload(12'h342, 64'h11);
    // flush while in WB
    issue(CSR_WRITE, 12'h342, 5'd0, 1'b0, 64'h22, 1'b0, 1'b0, ok);
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.csr_wr_en_o !== 1'b0) begin bad++; $display("FAIL flush_wb_wr got %b exp 0", bus.csr_wr_en_o); end
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
      bad++; $display("FAIL flush_wb_next got rdy=%b v=%b exp rdy=1 v=0", bus.in_ready_o, bus.out_valid_o);
    end
    total++;
    if (csr_file[12'h342] !== 64'h11) begin bad++; $display("FAIL flush_wb_unchanged got %h exp 11", csr_file[12'h342]); end
    // flush while in RD
    issue(CSR_READ, 12'h342, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0, ok);
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    vcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.out_valid_o !== 1'b0 || bus.csr_rd_en_o !== 1'b0) vcount++;
    end
    total++;
    if (vcount != 0 || bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_rd got active_cycles=%0d rdy=%b exp 0 rdy=1", vcount, bus.in_ready_o);
    end
    // flush while in RESP
    bus.out_ready_i = 1'b0;
    issue(CSR_READ, 12'h342, 5'd0, 1'b0, 64'h0, 1'b0, 1'b0, ok);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid_o === 1'b1) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    total++;
    if (!seen || bus.out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_resp got seen=%b v=%b exp seen=1 v=0", seen, bus.out_valid_o); end
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_resp_next got v=%b rdy=%b exp v=0 rdy=1", bus.out_valid_o, bus.in_ready_o);
    end
    // flush while IDLE blocks acceptance
    @(posedge clk); #1;
    bus.flush_i = 1'b1; bus.in_valid_i = 1'b1; bus.csr_op_i = CSR_READ; bus.csr_addr_i = 12'h342;
    @(negedge clk);
    total++;
    if (bus.in_ready_o !== 1'b0) begin bad++; $display("FAIL flush_idle_ready got %b exp 0", bus.in_ready_o); end
    @(posedge clk); #1;
    bus.flush_i = 1'b0; bus.in_valid_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus.csr_rd_en_o !== 1'b0 || bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL flush_idle_noaccept got rd=%b rdy=%b exp rd=0 rdy=1", bus.csr_rd_en_o, bus.in_ready_o);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    preload(12'h343, 64'h1);
    issue(CSR_WRITE, 12'h343, 5'd0, 1'b0, 64'h77, 1'b0, 1'b0, ok);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.in_ready_o, bus.csr_rd_en_o, bus.csr_wr_en_o, bus.out_valid_o} !== 4'b0 ||
        bus.csr_rd_addr_o !== 12'h0 || bus.out_rd_data_o !== 64'h0) begin
      bad++; $display("FAIL reset_mid_outputs got rdy=%b rd=%b wr=%b v=%b ra=%h exp all 0",
                      bus.in_ready_o, bus.csr_rd_en_o, bus.csr_wr_en_o, bus.out_valid_o, bus.csr_rd_addr_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (csr_file[12'h343] !== 64'h1 || bus.in_ready_o !== 1'b1) begin
      bad++; $display("FAIL reset_mid_after got csr=%h rdy=%b exp csr=1 rdy=1", csr_file[12'h343], bus.in_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    logic ok;
    logic [11:0] addrs [4];
    addrs[0] = 12'h300; addrs[1] = 12'h301; addrs[2] = 12'hC00; addrs[3] = ERR_ADDR;
    preload(12'h301, 64'hF0F0);
    for (int i = 0; i < 12; i++) begin
      issue(csr_op_e'(3'($urandom_range(0, 4))), addrs[$urandom_range(0, 3)],
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0), 1'b1, ok);
    end
    wait_done();
  endtask

  initial begin
    test_reset();
    test_write();
    test_set_clear();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
